mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to response valid; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 14, word-index width; the array holds 2^ADDR_BITS 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  byte-lane enables for a store; bit i selects bits [8i+7:8i].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-014 resp_err  output  1  the request was misaligned and was not performed.

Function
REQ-015 The block SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, and resp_valid SHALL be 1 only in RESP.
REQ-017 Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1.
  - At that edge the block SHALL capture req_write, req_addr, req_wdata and req_wstrb.
  - It SHALL load the wait counter with LATENCY-1 and enter BUSY.
REQ-018 In BUSY the counter SHALL decrement on each edge; on the edge where it is 0, the state SHALL become RESP.
  - Net effect: resp_valid is first high after the LATENCY-th edge following acceptance.
REQ-019 On the BUSY->RESP edge the block SHALL commit the operation:
  - Store: write the enabled lanes of the captured wdata to word addr[ADDR_BITS+1:2]; other lanes are unchanged.
  - Load: register that word into resp_rdata.
REQ-020 Address bits above ADDR_BITS+1 SHALL be ignored, so addresses wrap modulo the array size.
REQ-021 If addr[1:0] != 0, the block SHALL skip the array access and set resp_err=1 and resp_rdata=0; latency is unchanged.
REQ-022 A store with wstrb=0 SHALL complete normally with no array change and resp_err=0.
REQ-023 In RESP, resp_rdata and resp_err SHALL stay stable until the edge where resp_ready=1; that edge SHALL return the state to IDLE.
REQ-024 A new request SHALL NOT be accepted in the same cycle a response is consumed; the earliest next acceptance is the edge after the return to IDLE.
REQ-025 req_valid asserted in BUSY or RESP SHALL be ignored, with no capture and no side effect.
REQ-026 A load that follows a store to the same word SHALL return the stored data (read-after-write ordering is guaranteed by serialization).

Reset
REQ-027 Asserting reset SHALL immediately force:
  - state IDLE and counter 0;
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 Reset in BUSY SHALL abandon the request; a pending store SHALL NOT be written.
REQ-029 Array contents SHALL NOT be altered by reset.
REQ-030 Reset deassertion SHALL be the only prerequisite for accepting a request on the next rising edge.

Verification
REQ-031 Store then load (LATENCY=4):
  - Store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF: resp_valid rises exactly 4 edges after acceptance with err=0.
  - Then load addr 0x10: resp_rdata=0xDEADBEEF.
REQ-032 Partial store: word 0x20 holds 0x11223344; store wdata 0xAABBCCDD, wstrb 0x5 -> a later load returns 0x11BB33DD.
REQ-033 Misaligned: load addr 0x22 -> resp_err=1, resp_rdata=0 after 4 edges; memory is unchanged.
REQ-034 Backpressure: hold resp_ready=0 for 6 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0; req_valid pulses in that window are ignored.
REQ-035 Reset mid-op: assert reset 2 edges after accepting a store to 0x30 -> outputs return to reset values immediately; a subsequent load of 0x30 returns the old contents.
REQ-036 Wrap and edge latency:
  - With LATENCY=1: a store to byte address 0x0001_0000 (ADDR_BITS=14) aliases to word 0.
  - resp_valid is high after 1 edge.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory behind a valid/ready request/response handshake with fixed latency
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_BITS+1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [0:(1<<ADDR_BITS)-1];
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_misaligned;
  logic [ADDR_BITS-1:0]  w_idx;
  logic                  w_unused;
  // high address bits wrap away, so they never reach a register
  assign w_unused     = &{1'b0, req_addr[31:ADDR_BITS+2]};
  assign w_accept     = req_valid && r_state == IDLE;
  assign w_commit     = r_state == BUSY && r_cnt == 4'd0;
  assign w_misaligned = |r_addr[1:0];
  assign w_idx        = r_addr[ADDR_BITS+1:2];
  assign resp_rdata   = r_rdata;
  assign resp_err     = r_err;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // next state: accept in IDLE, count out BUSY, hold RESP until consumed
  always_comb begin
    w_next = w_accept                          ? BUSY :
             w_commit                          ? RESP :
             (r_state == RESP && resp_ready)   ? IDLE : r_state;
  end
  // handshake outputs decoded from state
  always_comb begin
    req_ready  = r_state == IDLE;
    resp_valid = r_state == RESP;
  end
  // capture the request and run the wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_cnt   <= LOAD_CNT;
      r_write <= req_write;
      r_addr  <= req_addr[ADDR_BITS+1:0];
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end else if (r_state == BUSY && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
  // response registers, updated only when the operation commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_misaligned;
      r_rdata <= (w_misaligned || r_write) ? 32'd0 : r_mem[w_idx];
    end
  end
  // array write: enabled lanes only, never touched by reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_commit && r_write && !w_misaligned && r_wstrb[i])
        r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a word-map reference model
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_ready = 1'b0;
  logic [1:0]  rdy, vld, err;
  logic [31:0] rd4, rd1;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl [int];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .ADDR_BITS(14)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(vld[0]), .resp_ready(resp_ready), .resp_rdata(rd4), .resp_err(err[0]));

  mem_responder #(.LATENCY(1), .ADDR_BITS(14)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(vld[1]), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(err[1]));

  assign req_ready  = rdy[sel];
  assign resp_valid = vld[sel];
  assign resp_err   = err[sel];
  assign resp_rdata = sel ? rd1 : rd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic junk();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'b1;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'hF;
  endtask

  // one complete transaction; the model is a map from word index to contents
  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int hold);
    int          n;
    int          key;
    bit          mis;
    logic [31:0] word, exp_rd;
    mis    = a[1:0] != 2'b00;
    key    = int'((a >> 2) & 32'h3FFF) + (sel ? 32'h10000 : 0);
    word   = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
    exp_rd = (w || mis) ? 32'd0 : word;
    if (w && !mis)
      for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
    if (w && !mis && s != 4'd0) mdl[key] = word;
    chk("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    @(posedge clk); #1;
    n = 0;
    while (!resp_valid && n < 20) begin
      junk();
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), sel ? 32'd1 : 32'd4);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", 32'(resp_err), 32'(mis));
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    last_rdata = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      junk();
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_err", 32'(resp_err), 32'(mis));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("consumed_valid", 32'(resp_valid), 32'd0);
    chk("consumed_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = 1'(k);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
    end
    sel = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    op(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    op(0, 32'h10, 32'd0, 4'h0, 0);
    chk("store_load_const", last_rdata, 32'hDEADBEEF);
    op(1, 32'h20, 32'h11223344, 4'hF, 0);
    op(1, 32'h20, 32'hAABBCCDD, 4'h5, 0);
    op(0, 32'h20, 32'd0, 4'h0, 0);
    chk("partial_const", last_rdata, 32'h11BB33DD);
    op(1, 32'h20, 32'h55555555, 4'h0, 0);
    op(0, 32'h22, 32'd0, 4'h0, 0);
    op(1, 32'h22, 32'hFFFFFFFF, 4'hF, 0);
    op(0, 32'h20, 32'd0, 4'h0, 0);
    chk("misaligned_unchanged", last_rdata, 32'h11BB33DD);
    op(0, 32'h10, 32'd0, 4'h0, 6);
    op(1, 32'h30, 32'h0BADF00D, 4'hF, 0);
    op(0, 32'h10, 32'd0, 4'h0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midop_ready", 32'(req_ready), 32'd1);
    chk("midop_valid", 32'(resp_valid), 32'd0);
    chk("midop_rdata", resp_rdata, 32'd0);
    chk("midop_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    op(0, 32'h30, 32'd0, 4'h0, 0);
    chk("abandoned_store", last_rdata, 32'h0BADF00D);
    for (int k = 0; k < 8; k++) op(1, 32'h40 + 32'(4 * k), $urandom, 4'hF, 0);
    for (int t = 0; t < 40; t++)
      op(1'($urandom_range(0, 1)),
         32'h40 + 32'(4 * $urandom_range(0, 7)) + ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'd0)
           + 32'($urandom_range(0, 3) << 16),
         $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    sel = 1'b1;
    op(1, 32'h0, 32'h01020304, 4'hF, 0);
    op(1, 32'h0001_0000, 32'hCAFEF00D, 4'hF, 1);
    op(0, 32'h0, 32'd0, 4'h0, 0);
    chk("wrap_const", last_rdata, 32'hCAFEF00D);
    for (int k = 0; k < 4; k++) op(1, 32'h80 + 32'(4 * k), $urandom, 4'hF, 0);
    for (int t = 0; t < 15; t++)
      op(1'($urandom_range(0, 1)),
         32'h80 + 32'(4 * $urandom_range(0, 3)) + ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'd0),
         $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
